duck_round_ctrl: RTL and testbench

Game-flow controller for the Duck Hunt datapath. Sequences each round: spawns birds, budgets shots per bird, resolves each bird as hit or miss, and drives the 2-bit game `state` and the one-cycle `bird_shot` award pulse consumed by the score keeper. Sits between the gun/hit-detection logic and the score/VGA blocks. It also clears the score at game start.

---
 rtl/duck_round_ctrl_if.sv | 27 ++
 rtl/duck_round_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_duck_round_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/duck_round_ctrl_if.sv
// rtl/duck_round_ctrl_if.sv - player inputs and game-flow outputs of the round controller
interface duck_round_ctrl_if;
    logic       start_btn;
    logic       trigger;
    logic       bird_hit;
    logic       frame_tick;
    logic [1:0] state;
    logic       bird_spawn;
    logic       bird_shot;
    logic       score_clear;
    logic [1:0] shots_left;
    logic [3:0] birds_done;
    logic [3:0] hits;
    logic [7:0] round;

    modport master (
        output start_btn, trigger, bird_hit, frame_tick,
        input  state, bird_spawn, bird_shot, score_clear,
        input  shots_left, birds_done, hits, round
    );

    modport slave (
        input  start_btn, trigger, bird_hit, frame_tick,
        output state, bird_spawn, bird_shot, score_clear,
        output shots_left, birds_done, hits, round
    );
endinterface

// File: rtl/duck_round_ctrl.sv
// rtl/duck_round_ctrl.sv - Duck Hunt round sequencer: spawns birds, budgets shots, resolves hit/miss
module duck_round_ctrl #(
    parameter int SHOTS_PER_BIRD  = 3,
    parameter int BIRDS_PER_ROUND = 10,
    parameter int PASS_HITS       = 6,
    parameter int FLYAWAY_FRAMES  = 300,
    parameter int END_FRAMES      = 120
) (
    input logic              Clk,
    input logic              Reset,
    duck_round_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_PLAY      = 2'b01,
        S_ROUND_END = 2'b10,
        S_GAME_OVER = 2'b11
    } state_t;

    localparam logic [1:0] SHOTS_INIT = 2'(SHOTS_PER_BIRD);
    localparam logic [3:0] BIRDS_MAX  = 4'(BIRDS_PER_ROUND);
    localparam logic [3:0] PASS_MIN   = 4'(PASS_HITS);
    localparam logic [9:0] FLY_LIMIT  = 10'(FLYAWAY_FRAMES);
    localparam logic [9:0] END_LIMIT  = 10'(END_FRAMES);

    state_t     state_q, state_n;
    logic [1:0] shots_q, shots_n;
    logic [3:0] done_q, done_n;
    logic [3:0] hits_q, hits_n;
    logic [7:0] round_q, round_n;
    logic [9:0] fcnt_q, fcnt_n;
    logic       active_q, active_n;
    logic       grace_q, grace_n;
    logic       spawn_q, spawn_n;
    logic       shot_q, shot_n;
    logic       clear_q, clear_n;
    logic       start_prev, trig_prev, hit_prev;
    logic       start_edge, trig_edge, hit_edge;
    logic       resolve;

    assign start_edge = bus.start_btn & ~start_prev;
    assign trig_edge  = bus.trigger   & ~trig_prev;
    assign hit_edge   = bus.bird_hit  & ~hit_prev;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            shots_q    <= '0;
            done_q     <= '0;
            hits_q     <= '0;
            round_q    <= '0;
            fcnt_q     <= '0;
            active_q   <= 1'b0;
            grace_q    <= 1'b0;
            spawn_q    <= 1'b0;
            shot_q     <= 1'b0;
            clear_q    <= 1'b0;
            start_prev <= 1'b0;
            trig_prev  <= 1'b0;
            hit_prev   <= 1'b0;
        end else begin
            state_q    <= state_n;
            shots_q    <= shots_n;
            done_q     <= done_n;
            hits_q     <= hits_n;
            round_q    <= round_n;
            fcnt_q     <= fcnt_n;
            active_q   <= active_n;
            grace_q    <= grace_n;
            spawn_q    <= spawn_n;
            shot_q     <= shot_n;
            clear_q    <= clear_n;
            start_prev <= bus.start_btn;
            trig_prev  <= bus.trigger;
            hit_prev   <= bus.bird_hit;
        end
    end

    always_comb begin
        state_n  = state_q;
        shots_n  = shots_q;
        done_n   = done_q;
        hits_n   = hits_q;
        round_n  = round_q;
        fcnt_n   = fcnt_q;
        active_n = active_q;
        grace_n  = grace_q;
        spawn_n  = 1'b0;
        shot_n   = 1'b0;
        clear_n  = 1'b0;
        resolve  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_n  = S_PLAY;
                    round_n  = 8'd1;
                    hits_n   = '0;
                    done_n   = '0;
                    clear_n  = 1'b1;
                    spawn_n  = 1'b1;
                    shots_n  = SHOTS_INIT;
                    active_n = 1'b1;
                    grace_n  = 1'b0;
                    fcnt_n   = '0;
                end
            end

            S_PLAY: begin
                if (!active_q) begin
                    // Previous bird resolved last cycle; launch the next one.
                    spawn_n  = 1'b1;
                    shots_n  = SHOTS_INIT;
                    fcnt_n   = '0;
                    grace_n  = 1'b0;
                    active_n = 1'b1;
                end else begin
                    if (trig_edge && shots_q != 2'd0)
                        shots_n = shots_q - 2'd1;
                    if (bus.frame_tick)
                        fcnt_n = fcnt_q + 10'd1;

                    // A hit edge outranks both escape paths in the same cycle.
                    if (hit_edge) begin
                        shot_n  = 1'b1;
                        hits_n  = hits_q + 4'd1;
                        resolve = 1'b1;
                    end else if (bus.frame_tick && (grace_q || fcnt_n == FLY_LIMIT)) begin
                        resolve = 1'b1;
                    end else if (shots_n == 2'd0) begin
                        grace_n = 1'b1;
                    end

                    if (resolve) begin
                        done_n   = done_q + 4'd1;
                        active_n = 1'b0;
                        grace_n  = 1'b0;
                        if (done_n == BIRDS_MAX) begin
                            state_n = S_ROUND_END;
                            fcnt_n  = '0;
                        end
                    end
                end
            end

            S_ROUND_END: begin
                if (bus.frame_tick) begin
                    fcnt_n = fcnt_q + 10'd1;
                    if (fcnt_n == END_LIMIT) begin
                        if (hits_q >= PASS_MIN) begin
                            state_n  = S_PLAY;
                            round_n  = (round_q == 8'hFF) ? round_q : round_q + 8'd1;
                            hits_n   = '0;
                            done_n   = '0;
                            spawn_n  = 1'b1;
                            shots_n  = SHOTS_INIT;
                            active_n = 1'b1;
                            grace_n  = 1'b0;
                            fcnt_n   = '0;
                        end else begin
                            state_n = S_GAME_OVER;
                        end
                    end
                end
            end

            S_GAME_OVER: begin
                if (start_edge)
                    state_n = S_IDLE;
            end

            default: state_n = S_IDLE;
        endcase
    end

    assign bus.state       = state_q;
    assign bus.bird_spawn  = spawn_q;
    assign bus.bird_shot   = shot_q;
    assign bus.score_clear = clear_q;
    assign bus.shots_left  = shots_q;
    assign bus.birds_done  = done_q;
    assign bus.hits        = hits_q;
    assign bus.round       = round_q;

endmodule

// File: tb/tb_duck_round_ctrl.sv
// tb/tb_duck_round_ctrl.sv - table and sequence driven scoreboard bench for duck_round_ctrl
module tb_duck_round_ctrl;

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] sl;
        logic [3:0] bd;
        logic [3:0] hc;
        logic [7:0] rd;
        logic       sp;
        logic       sh;
        logic       cl;
    } out_t;

    typedef struct {
        logic  s, t, h, f;
        out_t  exp;
        string name;
    } vec_t;

    typedef struct {
        out_t  exp;
        out_t  mask;
        string name;
    } sb_t;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_RE   = 2'b10;
    localparam logic [1:0] ST_GO   = 2'b11;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;
    logic [3:0] e_bd, e_hits;
    logic [7:0] e_round;
    out_t m_all, m_state;
    vec_t tbl[$];
    sb_t  sb_q[$];

    duck_round_ctrl_if bus();

    duck_round_ctrl #(
        .SHOTS_PER_BIRD (3),
        .BIRDS_PER_ROUND(10),
        .PASS_HITS      (6),
        .FLYAWAY_FRAMES (300),
        .END_FRAMES     (120)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic out_t mk(input logic [1:0] st, input logic [1:0] sl, input logic [3:0] bd,
                                input logic [3:0] hc, input logic [7:0] rd, input logic sp,
                                input logic sh, input logic cl);
        out_t o;
        o.st = st; o.sl = sl; o.bd = bd; o.hc = hc; o.rd = rd; o.sp = sp; o.sh = sh; o.cl = cl;
        return o;
    endfunction

    function automatic out_t sample();
        return mk(bus.state, bus.shots_left, bus.birds_done, bus.hits, bus.round,
                  bus.bird_spawn, bus.bird_shot, bus.score_clear);
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("state=%0d shots_left=%0d birds_done=%0d hits=%0d round=%0d spawn=%0d shot=%0d clear=%0d",
                         o.st, o.sl, o.bd, o.hc, o.rd, o.sp, o.sh, o.cl);
    endfunction

    task automatic drive(input logic s, input logic t, input logic h, input logic f);
        bus.start_btn = s; bus.trigger = t; bus.bird_hit = h; bus.frame_tick = f;
        @(posedge Clk);
        #1;
    endtask

    task automatic step(input logic s, input logic t, input logic h, input logic f,
                        input out_t exp, input out_t mask, input string name);
        sb_t        e;
        out_t       act;
        logic [22:0] diff;
        sb_q.push_back('{exp, mask, name});
        drive(s, t, h, f);
        act  = sample();
        e    = sb_q.pop_front();
        diff = (act ^ e.exp) & e.mask;
        checks++;
        if (diff != '0) begin
            errors++;
            $display("FAIL %s: got %s | expected %s", e.name, fmt(act), fmt(e.exp));
        end
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 1);
            drive(0, 0, 0, 0);
        end
    endtask

    task automatic add(input logic s, input logic t, input logic h, input logic f,
                       input out_t exp, input string name);
        tbl.push_back('{s, t, h, f, exp, name});
    endtask

    task automatic hit_bird();
        e_bd   = e_bd + 4'd1;
        e_hits = e_hits + 4'd1;
        step(0, 0, 1, 0, mk((e_bd == 4'd10) ? ST_RE : ST_PLAY, 3, e_bd, e_hits, e_round, 0, 1, 0),
             m_all, "hit_credit");
        if (e_bd == 4'd10)
            step(0, 0, 0, 0, mk(ST_RE, 3, e_bd, e_hits, e_round, 0, 0, 0), m_all, "hit_round_end");
        else
            step(0, 0, 0, 0, mk(ST_PLAY, 3, e_bd, e_hits, e_round, 1, 0, 0), m_all, "hit_respawn");
    endtask

    task automatic miss_bird();
        step(0, 1, 0, 0, mk(ST_PLAY, 2, e_bd, e_hits, e_round, 0, 0, 0), m_all, "miss_shot1");
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        step(0, 1, 0, 0, mk(ST_PLAY, 0, e_bd, e_hits, e_round, 0, 0, 0), m_all, "miss_shot3");
        drive(0, 0, 0, 0);
        e_bd = e_bd + 4'd1;
        step(0, 0, 0, 1, mk((e_bd == 4'd10) ? ST_RE : ST_PLAY, 0, e_bd, e_hits, e_round, 0, 0, 0),
             m_all, "miss_grace_tick");
        if (e_bd == 4'd10)
            step(0, 0, 0, 0, mk(ST_RE, 0, e_bd, e_hits, e_round, 0, 0, 0), m_all, "miss_round_end");
        else
            step(0, 0, 0, 0, mk(ST_PLAY, 3, e_bd, e_hits, e_round, 1, 0, 0), m_all, "miss_respawn");
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_all   = '1;
        m_state = mk(2'b11, 0, 0, 0, 0, 1, 1, 1);
        bus.start_btn = 0; bus.trigger = 0; bus.bird_hit = 0; bus.frame_tick = 0;
        Reset = 1'b1;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        step(0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0), m_all, "reset_values");
        Reset = 1'b0;
        drive(0, 0, 0, 0);

        // start, shot budget with grace miss, hit credit, hit-vs-grace priority
        add(1, 0, 0, 0, mk(ST_PLAY, 3, 0, 0, 1, 1, 0, 1), "start");
        add(1, 0, 0, 0, mk(ST_PLAY, 3, 0, 0, 1, 0, 0, 0), "start_held");
        add(0, 1, 0, 0, mk(ST_PLAY, 2, 0, 0, 1, 0, 0, 0), "shot1");
        add(0, 0, 0, 0, mk(ST_PLAY, 2, 0, 0, 1, 0, 0, 0), "shot1_low");
        add(0, 1, 0, 0, mk(ST_PLAY, 1, 0, 0, 1, 0, 0, 0), "shot2");
        add(0, 0, 0, 0, mk(ST_PLAY, 1, 0, 0, 1, 0, 0, 0), "shot2_low");
        add(0, 1, 0, 0, mk(ST_PLAY, 0, 0, 0, 1, 0, 0, 0), "shot3");
        add(0, 0, 0, 0, mk(ST_PLAY, 0, 0, 0, 1, 0, 0, 0), "shot3_low");
        add(0, 1, 0, 0, mk(ST_PLAY, 0, 0, 0, 1, 0, 0, 0), "shot4_ignored");
        add(0, 0, 0, 1, mk(ST_PLAY, 0, 1, 0, 1, 0, 0, 0), "grace_miss");
        add(0, 0, 0, 0, mk(ST_PLAY, 3, 1, 0, 1, 1, 0, 0), "spawn_after_miss");
        add(0, 0, 0, 0, mk(ST_PLAY, 3, 1, 0, 1, 0, 0, 0), "spawn_pulse_end");
        add(0, 1, 1, 0, mk(ST_PLAY, 2, 2, 1, 1, 0, 1, 0), "trig_and_hit");
        add(0, 0, 1, 0, mk(ST_PLAY, 3, 2, 1, 1, 1, 0, 0), "hit_held_spawn");
        add(0, 0, 1, 0, mk(ST_PLAY, 3, 2, 1, 1, 0, 0, 0), "hit_held_a");
        add(0, 0, 1, 0, mk(ST_PLAY, 3, 2, 1, 1, 0, 0, 0), "hit_held_b");
        add(0, 0, 0, 0, mk(ST_PLAY, 3, 2, 1, 1, 0, 0, 0), "hit_release");
        add(0, 1, 0, 0, mk(ST_PLAY, 2, 2, 1, 1, 0, 0, 0), "g_shot1");
        add(0, 0, 0, 0, mk(ST_PLAY, 2, 2, 1, 1, 0, 0, 0), "g_shot1_low");
        add(0, 1, 0, 0, mk(ST_PLAY, 1, 2, 1, 1, 0, 0, 0), "g_shot2");
        add(0, 0, 0, 0, mk(ST_PLAY, 1, 2, 1, 1, 0, 0, 0), "g_shot2_low");
        add(0, 1, 0, 0, mk(ST_PLAY, 0, 2, 1, 1, 0, 0, 0), "g_shot3");
        add(0, 0, 0, 0, mk(ST_PLAY, 0, 2, 1, 1, 0, 0, 0), "g_shot3_low");
        add(0, 0, 1, 1, mk(ST_PLAY, 0, 3, 2, 1, 0, 1, 0), "hit_beats_grace");
        add(0, 0, 0, 0, mk(ST_PLAY, 3, 3, 2, 1, 1, 0, 0), "spawn_after_hit");
        foreach (tbl[i])
            step(tbl[i].s, tbl[i].t, tbl[i].h, tbl[i].f, tbl[i].exp, m_all, tbl[i].name);

        // flyaway escape, then a hit on the expiring tick
        idle_ticks(299);
        step(0, 0, 0, 0, mk(ST_PLAY, 3, 3, 2, 1, 0, 0, 0), m_all, "flyaway_299");
        step(0, 0, 0, 1, mk(ST_PLAY, 3, 4, 2, 1, 0, 0, 0), m_all, "flyaway_miss");
        step(0, 0, 0, 0, mk(ST_PLAY, 3, 4, 2, 1, 1, 0, 0), m_all, "flyaway_respawn");
        idle_ticks(299);
        step(0, 0, 1, 1, mk(ST_PLAY, 3, 5, 3, 1, 0, 1, 0), m_all, "flyaway_hit");
        step(0, 0, 0, 0, mk(ST_PLAY, 3, 5, 3, 1, 1, 0, 0), m_all, "flyaway_hit_respawn");

        // round 1 closes with 6 hits, 4 misses and advances
        e_bd = 4'd5; e_hits = 4'd3; e_round = 8'd1;
        for (int i = 0; i < 3; i++) hit_bird();
        for (int i = 0; i < 2; i++) miss_bird();
        step(0, 0, 1, 0, mk(ST_RE, 0, 10, 6, 1, 0, 0, 0), m_all, "re_hit_ignored");
        step(0, 1, 0, 0, mk(ST_RE, 0, 10, 6, 1, 0, 0, 0), m_all, "re_trig_ignored");
        drive(0, 0, 0, 0);
        idle_ticks(119);
        step(0, 0, 0, 0, mk(ST_RE, 0, 10, 6, 1, 0, 0, 0), m_all, "re_tick_119");
        step(0, 0, 0, 1, mk(ST_PLAY, 3, 0, 0, 2, 1, 0, 0), m_all, "round_advance");

        // round 2 falls short with 5 hits
        e_bd = 4'd0; e_hits = 4'd0; e_round = 8'd2;
        for (int i = 0; i < 5; i++) hit_bird();
        for (int i = 0; i < 5; i++) miss_bird();
        idle_ticks(119);
        step(0, 0, 0, 1, mk(ST_GO, 0, 10, 5, 2, 0, 0, 0), m_all, "game_over");
        step(0, 0, 1, 0, mk(ST_GO, 0, 10, 5, 2, 0, 0, 0), m_all, "go_hit_ignored");
        step(1, 0, 0, 0, mk(ST_IDLE, 0, 0, 0, 0, 0, 0, 0), m_state, "go_to_idle");
        drive(0, 0, 0, 0);
        step(1, 0, 0, 0, mk(ST_PLAY, 3, 0, 0, 1, 1, 0, 1), m_all, "restart");
        drive(0, 0, 0, 0);

        // reset mid-round with three hits banked
        e_bd = 4'd0; e_hits = 4'd0; e_round = 8'd1;
        for (int i = 0; i < 3; i++) hit_bird();
        Reset = 1'b1;
        step(0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0), m_all, "reset_mid_round");
        Reset = 1'b0;
        step(0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0), m_all, "idle_hit_ignored");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
